// File: rtl/bitrev_seq.sv
// Sequencer for a two-sample-per-beat bit-reverse stage: feeds beats to the datapath,
// pads and drains partial frames on flush, and holds back output until a full frame is stored.
module bitrev_seq #(
    parameter int LGSIZE = 5,
    parameter int WIDTH  = 24
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [2*WIDTH-1:0] s_data_0,
    input  logic [2*WIDTH-1:0] s_data_1,
    input  logic               i_flush,
    output logic               br_reset,
    output logic               br_ce,
    output logic [2*WIDTH-1:0] br_in_0,
    output logic [2*WIDTH-1:0] br_in_1,
    input  logic               br_sync,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_sync,
    output logic               o_busy,
    output logic [15:0]        o_frames
);

    localparam int BW = LGSIZE - 1;
    localparam logic [BW-1:0]        BCNT_ZERO   = {BW{1'b0}};
    localparam logic [BW-1:0]        BCNT_ONE    = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0]        BCNT_LAST   = {BW{1'b1}};
    localparam logic [2*WIDTH-1:0]   ZERO_SAMPLE = {(2*WIDTH){1'b0}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_PAD    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_RESYNC = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [BW-1:0] bcnt_r;
    logic [BW-1:0] bcnt_nxt_s;
    logic          fresh_r;
    logic          primed_r;
    logic          drain_done_r;
    logic          avail_s;
    logic          from_src_s;
    logic          valid_s;
    logic          ce_s;
    logic          resync_s;

    // Beat source per state: upstream samples, zero fill, or nothing
    always_comb begin
        avail_s    = 1'b0;
        from_src_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_RUN: begin
                avail_s    = s_valid;
                from_src_s = 1'b1;
            end
            ST_PAD:    avail_s = 1'b1;
            ST_DRAIN:  avail_s = ~drain_done_r;
            ST_RESYNC: avail_s = 1'b0;
            default:   avail_s = 1'b0;
        endcase
    end

    // Output valid and clock enable; both held off while reset is asserted
    always_comb begin
        resync_s = (state_r == ST_RESYNC);
        if (i_reset) begin
            valid_s = 1'b0;
            ce_s    = 1'b0;
        end else begin
            valid_s = fresh_r & (primed_r | br_sync);
            ce_s    = avail_s & (~valid_s | m_ready);
        end
        bcnt_nxt_s = ce_s ? (bcnt_r + BCNT_ONE) : bcnt_r;
    end

    assign s_ready  = ce_s & from_src_s;
    assign br_ce    = ce_s;
    assign br_reset = i_reset | resync_s;
    assign br_in_0  = from_src_s ? s_data_0 : ZERO_SAMPLE;
    assign br_in_1  = from_src_s ? s_data_1 : ZERO_SAMPLE;
    assign m_valid  = valid_s;
    assign m_sync   = valid_s & br_sync;
    assign o_busy   = ~i_reset & ((state_r == ST_PAD) | (state_r == ST_DRAIN) | resync_s);

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ce_s) state_nxt_s = ST_RUN;
                else      state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (i_flush) begin
                    if (bcnt_nxt_s != BCNT_ZERO) state_nxt_s = ST_PAD;
                    else                         state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_PAD: begin
                if (ce_s && (bcnt_r == BCNT_LAST)) state_nxt_s = ST_DRAIN;
                else                               state_nxt_s = ST_PAD;
            end
            ST_DRAIN: begin
                // the last drained output must be taken before the datapath is reset
                if (drain_done_r && (~valid_s || m_ready)) state_nxt_s = ST_RESYNC;
                else                                       state_nxt_s = ST_DRAIN;
            end
            ST_RESYNC: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // State, beat counter, output tracking flags and frame counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r      <= ST_IDLE;
            bcnt_r       <= BCNT_ZERO;
            fresh_r      <= 1'b0;
            primed_r     <= 1'b0;
            drain_done_r <= 1'b0;
            o_frames     <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            if (resync_s) begin
                bcnt_r       <= BCNT_ZERO;
                fresh_r      <= 1'b0;
                primed_r     <= 1'b0;
                drain_done_r <= 1'b0;
            end else begin
                bcnt_r <= bcnt_nxt_s;
                if (ce_s)
                    fresh_r <= 1'b1;
                else if (valid_s && m_ready)
                    fresh_r <= 1'b0;
                if (fresh_r && br_sync)
                    primed_r <= 1'b1;
                if (ce_s && (state_r == ST_DRAIN) && (bcnt_r == BCNT_LAST))
                    drain_done_r <= 1'b1;
            end
            if (valid_s && br_sync && m_ready)
                o_frames <= o_frames + 16'd1;
        end
    end

endmodule
